// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code event decoder.
// Prefix bytes, discard codes, FSM state and a byte classifier live here.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Controller/status bytes that are never part of a key sequence
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_PAUSE   = 8'hE1;

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } ps2_state_e;

    typedef enum logic [1:0] {
        BYTE_KEY     = 2'd0,
        BYTE_EXT     = 2'd1,
        BYTE_BRK     = 2'd2,
        BYTE_DISCARD = 2'd3
    } ps2_byte_e;

    function automatic ps2_byte_e ps2_classify(input logic [7:0] b);
        ps2_byte_e c;
        case (b)
            PS2_PFX_EXT: c = BYTE_EXT;
            PS2_PFX_BRK: c = BYTE_BRK;
            PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_PAUSE: c = BYTE_DISCARD;
            default:     c = BYTE_KEY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ps2_key_event_if.sv
// Link between the PS/2 receiver FIFO (master) and the key-event decoder (slave).
// Handshake: fifo_data is valid whenever fifo_ready=1; the slave pops the head byte by
// driving nextdata_n=0 for exactly one cycle, and the FIFO advances on that cycle's clock edge.
interface ps2_key_event_if;
    logic [7:0] fifo_data;
    logic       fifo_ready;
    logic       fifo_overflow;
    logic       nextdata_n;

    modport master (
        output fifo_data,
        output fifo_ready,
        output fifo_overflow,
        input  nextdata_n
    );

    modport slave (
        input  fifo_data,
        input  fifo_ready,
        input  fifo_overflow,
        output nextdata_n
    );
endinterface

// File: rtl/ps2_held_tracker.sv
// Held-key state, typematic repeat detection and the wrapping press counter.
// Updates only on completed key events from the parent decoder.
module ps2_held_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             i_evt,
    input  logic             i_brk,
    input  logic             i_ext,
    input  logic [7:0]       i_code,
    output logic             o_repeat,
    output logic             o_held_valid,
    output logic [7:0]       o_held_code,
    output logic [CNT_W-1:0] o_press_cnt
);

    logic             r_held_valid;
    logic             r_held_ext;
    logic [7:0]       r_held_code;
    logic [CNT_W-1:0] r_press_cnt;
    logic             w_match;

    assign w_match  = r_held_valid && (r_held_code == i_code) && (r_held_ext == i_ext);
    assign o_repeat = w_match && !i_brk;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_held_valid <= 1'b0;
            r_held_ext   <= 1'b0;
            r_held_code  <= 8'h00;
            r_press_cnt  <= '0;
        end else if (i_evt) begin
            if (!i_brk) begin
                if (!w_match) begin
                    r_held_valid <= 1'b1;
                    r_held_ext   <= i_ext;
                    r_held_code  <= i_code;
                    r_press_cnt  <= r_press_cnt + 1'b1;
                end
            end else if (w_match) begin
                // Release keeps the last code visible for the display path
                r_held_valid <= 1'b0;
            end
        end
    end

    assign o_held_valid = r_held_valid;
    assign o_held_code  = r_held_code;
    assign o_press_cnt  = r_press_cnt;

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan-code consumer: pops receiver FIFO bytes, strips E0/F0 prefixes and
// emits one key event per completed sequence, with held-key tracking.
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    ps2_key_event_if.slave   fifo,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_repeat,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_err,
    output ps2_state_e       o_dbg_state
);

    ps2_state_e r_state;
    ps2_state_e w_state_nxt;

    logic [7:0] r_byte;
    logic       r_ext;
    logic       r_brk;
    logic       r_key_valid;
    logic [7:0] r_key_code;
    logic       r_key_ext;
    logic       r_key_release;
    logic       r_key_repeat;
    logic       r_ovf_err;

    logic       w_latch;
    logic       w_pop;
    logic       w_nextdata_n;
    logic       w_evt;
    logic       w_repeat;
    ps2_byte_e  w_class;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (fifo.fifo_ready) w_state_nxt = POP;
            POP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobe is gated by clrn so a reset landing mid-pop drops it at once
    always_comb begin
        w_latch      = (r_state == IDLE) && fifo.fifo_ready;
        w_pop        = (r_state == POP);
        w_nextdata_n = !(w_pop && clrn);
    end

    assign w_class = ps2_classify(r_byte);
    assign w_evt   = w_pop && (w_class == BYTE_KEY);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_byte        <= 8'h00;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_key_valid   <= 1'b0;
            r_key_code    <= 8'h00;
            r_key_ext     <= 1'b0;
            r_key_release <= 1'b0;
            r_key_repeat  <= 1'b0;
        end else begin
            r_key_valid <= w_evt;
            if (w_latch) begin
                r_byte <= fifo.fifo_data;
            end
            if (w_pop) begin
                case (w_class)
                    BYTE_EXT: r_ext <= 1'b1;
                    BYTE_BRK: r_brk <= 1'b1;
                    BYTE_DISCARD: begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end
                    default: begin
                        r_ext         <= 1'b0;
                        r_brk         <= 1'b0;
                        r_key_code    <= r_byte;
                        r_key_ext     <= r_ext;
                        r_key_release <= r_brk;
                        r_key_repeat  <= w_repeat;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_ovf_err <= 1'b0;
        end else if (fifo.fifo_overflow) begin
            r_ovf_err <= 1'b1;
        end
    end

    ps2_held_tracker #(
        .CNT_W (CNT_W)
    ) u_held (
        .clk          (clk),
        .clrn         (clrn),
        .i_evt        (w_evt),
        .i_brk        (r_brk),
        .i_ext        (r_ext),
        .i_code       (r_byte),
        .o_repeat     (w_repeat),
        .o_held_valid (held_valid),
        .o_held_code  (held_code),
        .o_press_cnt  (press_cnt)
    );

    assign fifo.nextdata_n = w_nextdata_n;
    assign key_valid       = r_key_valid;
    assign key_code        = r_key_code;
    assign key_ext         = r_key_ext;
    assign key_release     = r_key_release;
    assign key_repeat      = r_key_repeat;
    assign ovf_err         = r_ovf_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: a queue-backed FIFO model feeds bytes and a
// scoreboard of expected events is checked whenever key_valid fires.
module tb_ps2_key_event;
    import ps2_pkg::*;

    localparam int CNT_W = 8;
    localparam int EW    = 8 + 1 + 1 + 1 + CNT_W + 1 + 8;

    logic             clk = 1'b0;
    logic             clrn;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_release;
    logic             key_repeat;
    logic             held_valid;
    logic [7:0]       held_code;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_err;
    ps2_state_e       dbg_state;

    ps2_key_event_if u_fifo ();

    ps2_key_event #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .fifo        (u_fifo),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .held_valid  (held_valid),
        .held_code   (held_code),
        .press_cnt   (press_cnt),
        .ovf_err     (ovf_err),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [7:0]    src_q[$];
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            pop_cnt  = 0;
    logic          prev_nd  = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic exp_ev(input logic [7:0] code, input logic ext, input logic rel,
                          input logic rep, input logic [CNT_W-1:0] cnt, input logic hv,
                          input logic [7:0] hc);
        exp_q.push_back({code, ext, rel, rep, cnt, hv, hc});
    endtask

    task automatic push(input logic [7:0] b);
        src_q.push_back(b);
    endtask

    // FIFO model and event monitor, all sampled on the falling edge
    initial begin
        logic [EW-1:0] e;
        u_fifo.fifo_ready = 1'b0;
        u_fifo.fifo_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (key_valid) begin
                check("unexpected_event", 32'(exp_q.size() != 0), 32'd1);
                check("event_latency", 32'(prev_nd), 32'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("event", 32'({key_code, key_ext, key_release, key_repeat,
                                         press_cnt, held_valid, held_code}), 32'(e));
                end
            end
            if (!u_fifo.nextdata_n) begin
                check("single_pop", 32'(prev_nd), 32'd1);
                pop_cnt++;
                if (src_q.size() != 0) void'(src_q.pop_front());
            end
            prev_nd           = u_fifo.nextdata_n;
            u_fifo.fifo_ready = (src_q.size() != 0);
            u_fifo.fifo_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
        end
    end

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || u_fifo.fifo_ready) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        #1;
        check(tag, 32'(cyc < 2000), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] c;
        clrn                 = 1'b0;
        u_fifo.fifo_overflow = 1'b0;

        // Reset with a byte already waiting
        push(8'h1C);
        exp_ev(8'h1C, 0, 0, 0, 8'd1, 1, 8'h1C);
        repeat (3) @(negedge clk);
        #1;
        check("rst_nextdata_n", 32'(u_fifo.nextdata_n), 32'd1);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_press_cnt", 32'(press_cnt), 32'd0);
        check("rst_held_valid", 32'(held_valid), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        check("rst_dbg_state", 32'(dbg_state), 32'(IDLE));
        clrn = 1'b1;
        #1;
        check("first_cycle_no_pop", 32'(u_fifo.nextdata_n), 32'd1);
        @(negedge clk);
        #1;
        check("first_pop", 32'(u_fifo.nextdata_n), 32'd0);

        // Single key make/break
        push(8'hF0); push(8'h1C);
        exp_ev(8'h1C, 0, 1, 0, 8'd1, 0, 8'h1C);
        drain("single_done");
        check("single_pops", 32'(pop_cnt), 32'd3);

        // Typematic repeat
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        exp_ev(8'h1C, 0, 0, 0, 8'd2, 1, 8'h1C);
        exp_ev(8'h1C, 0, 0, 1, 8'd2, 1, 8'h1C);
        exp_ev(8'h1C, 0, 0, 1, 8'd2, 1, 8'h1C);
        exp_ev(8'h1C, 0, 1, 0, 8'd2, 0, 8'h1C);
        drain("typematic_done");

        // Extended make/break
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        exp_ev(8'h75, 1, 0, 0, 8'd3, 1, 8'h75);
        exp_ev(8'h75, 1, 1, 0, 8'd3, 0, 8'h75);
        drain("extended_done");

        // Same code, different ext; F0,E0 order; break of a non-held key
        push(8'hE0); push(8'h75);
        exp_ev(8'h75, 1, 0, 0, 8'd4, 1, 8'h75);
        push(8'h75);
        exp_ev(8'h75, 0, 0, 0, 8'd5, 1, 8'h75);
        push(8'hF0); push(8'hE0); push(8'h75);
        exp_ev(8'h75, 1, 1, 0, 8'd5, 1, 8'h75);
        push(8'hF0); push(8'h75);
        exp_ev(8'h75, 0, 1, 0, 8'd5, 0, 8'h75);
        push(8'hF0); push(8'h33);
        exp_ev(8'h33, 0, 1, 0, 8'd5, 0, 8'h75);
        drain("distinct_done");

        // Discard bytes, including clearing of pending prefixes
        push(8'hFA); push(8'h1C);
        exp_ev(8'h1C, 0, 0, 0, 8'd6, 1, 8'h1C);
        push(8'hE0); push(8'hFA); push(8'h1C);
        exp_ev(8'h1C, 0, 0, 1, 8'd6, 1, 8'h1C);
        push(8'hF0); push(8'hFA); push(8'h1C);
        exp_ev(8'h1C, 0, 0, 1, 8'd6, 1, 8'h1C);
        push(8'hAA); push(8'hEE); push(8'hFE); push(8'hE1); push(8'hF0); push(8'h1C);
        exp_ev(8'h1C, 0, 1, 0, 8'd6, 0, 8'h1C);
        drain("discard_done");

        // Sticky overflow
        check("ovf_before", 32'(ovf_err), 32'd0);
        @(negedge clk);
        #1;
        u_fifo.fifo_overflow = 1'b1;
        @(negedge clk);
        #1;
        u_fifo.fifo_overflow = 1'b0;
        check("ovf_set", 32'(ovf_err), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Counter wrap over 256 distinct presses
        c = 8'd6;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] k;
            k = (i % 2 == 0) ? 8'h15 : 8'h16;
            c = c + 1'b1;
            push(k);
            exp_ev(k, 0, 0, 0, c, 1, k);
        end
        drain("wrap_done");
        check("wrap_cnt", 32'(press_cnt), 32'd6);
        check("ovf_after_decode", 32'(ovf_err), 32'd1);

        // Reset landing in the POP cycle
        push(8'h44);
        begin
            int cyc;
            cyc = 0;
            while (cyc < 50) begin
                @(negedge clk);
                cyc++;
                if (!u_fifo.nextdata_n) break;
            end
            check("pop_seen", 32'(cyc < 50), 32'd1);
        end
        #1;
        clrn = 1'b0;
        #1;
        check("rst_pop_nextdata_n", 32'(u_fifo.nextdata_n), 32'd1);
        @(negedge clk);
        #1;
        check("rst_pop_key_valid", 32'(key_valid), 32'd0);
        check("rst_pop_press_cnt", 32'(press_cnt), 32'd0);
        check("rst_pop_held_valid", 32'(held_valid), 32'd0);
        check("rst_pop_held_code", 32'(held_code), 32'd0);
        check("rst_pop_key_code", 32'(key_code), 32'd0);
        check("rst_pop_ovf_err", 32'(ovf_err), 32'd0);
        clrn = 1'b1;
        drain("post_reset_quiet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
- Downstream consumer of the PS/2 receiver FIFO (data/ready/nextdata_n/overflow interface).
- Pops one scan-code byte at a time and strips E0/F0 prefixes.
- Emits one decoded key event per complete sequence (make/break, extended, typematic-repeat flag).
- Tracks the currently held key and keeps a wrapping count of genuine key presses for the HEX display path.

Parameters:
- CNT_W, 8, width of the press counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock
- clrn  in  1  synchronous active-low reset, sampled on rising clk
- fifo_data  in  8  head byte from receiver FIFO, valid while fifo_ready=1
- fifo_ready  in  1  receiver FIFO non-empty
- fifo_overflow  in  1  receiver FIFO overflow indication
- nextdata_n  out  1  active-low pop strobe to receiver, one cycle per byte
- key_valid  out  1  one-cycle event strobe
- key_code  out  8  scan code of event (prefixes stripped)
- key_ext  out  1  event was E0-prefixed
- key_release  out  1  event is break (F0-prefixed)
- key_repeat  out  1  make event duplicates the currently held key (typematic)
- held_valid  out  1  a key is currently held
- held_code  out  8  code of the held key
- press_cnt  out  CNT_W  count of non-repeat make events
- ovf_err  out  1  sticky overflow flag

Behaviour:
- Reset (clrn=0 at a clk edge), all registers cleared:
  - nextdata_n=1, key_valid=0, key_code=0, key_ext=0, key_release=0, key_repeat=0.
  - held_valid=0, held_code=0, press_cnt=0, ovf_err=0.
  - Prefix flags cleared, FSM=IDLE.
  - A pop in progress when reset hits is abandoned: nextdata_n=1 from the first reset cycle.
- FSM states: IDLE, POP.
  - IDLE: if fifo_ready=1 in cycle N, latch fifo_data into the byte register and go to POP. nextdata_n=0 for exactly cycle N+1.
  - POP: always returns to IDLE. The byte is decoded at the end of cycle N+1.
  - The next byte can be sampled in N+2. Maximum throughput is one byte per 2 cycles.
- Decode of the latched byte:
  - E0: set ext flag, no event.
  - F0: set brk flag, no event. Prefix order E0,F0 or F0,E0 both accepted.
  - AA, FA, EE, FE, E1: discarded, prefix flags cleared, no event.
  - Any other byte completes the sequence and produces an event. Prefix flags are cleared.
- Event timing: key_valid=1 in cycle N+2 only. key_code, key_ext, key_release and key_repeat hold their values until the next event.
- Make event (brk=0):
  - If held_valid and held_code==code and held ext matches: key_repeat=1, press_cnt unchanged.
  - Otherwise: key_repeat=0, held_code<=code, held ext<=ext, held_valid<=1, press_cnt<=press_cnt+1 (wraps 0xFF->0x00 for CNT_W=8).
- Break event (brk=1):
  - key_repeat=0.
  - If code and ext match the held key: held_valid<=0. held_code retains its last value.
  - A break for a non-held key emits the event but leaves the held state untouched.
- ovf_err: set on any cycle with fifo_overflow=1; cleared only by reset. Decoding continues normally.
- fifo_ready dropping while in POP: ignored. The pop strobe is still issued once; the receiver guarantees pop-on-empty is harmless.
- Simultaneous reset and event: reset wins, key_valid=0.

Decomposition:
- Shared package ps2_pkg holds:
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
  - Discard codes 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1.
  - State enum {IDLE, POP}.
- One natural sub-module: ps2_held_tracker, which holds the held key/ext/valid state, does the repeat comparison and owns press_cnt. The parent keeps the FSM, pop handshake and prefix decode.

Test Plan:
- Reset: clrn=0 for 2 cycles with fifo_ready=1 -> nextdata_n=1, key_valid=0, press_cnt=0. First pop occurs the cycle after the first cycle with clrn=1.
- Single key: FIFO bytes 1C,F0,1C -> two events:
  - (1C, make, repeat=0), then (1C, release).
  - press_cnt=1, held_valid goes 1 then 0.
  - Each key_valid arrives 2 cycles after its byte is sampled.
  - nextdata_n low exactly 3 single cycles.
- Typematic: 1C,1C,1C,F0,1C -> makes with key_repeat=0,1,1, then release. press_cnt=1.
- Extended: E0,75,E0,F0,75 -> (75, ext=1, make), then (75, ext=1, release). Prefix bytes produce no key_valid.
- Distinct held: make 75 (no prefix) while E0 75 held -> key_repeat=0, press_cnt+1.
- Wrap and errors:
  - 256 distinct-alternating makes -> press_cnt wraps to 0.
  - fifo_overflow pulse -> ovf_err=1 until reset.
  - Byte FA -> no event.
  - Reset asserted during POP -> nextdata_n=1 immediately.
